// File: rtl/enemies_headsup_scheduler.sv
// Frame-synchronous round-robin owner of the single heads-up bracket drawer; outputs registered, 1 clk after startOfFrame.
// No backpressure: requests and positions are sampled only on frame-start cycles, everything else holds.
module enemies_headsup_scheduler #(
  parameter int NUM_ENEMIES    = 4,
  parameter int IDX_W          = 2,
  parameter int DISPLAY_FRAMES = 30,
  parameter int GAP_FRAMES     = 4,
  parameter int MIN_X          = 5,
  parameter int MIN_Y          = 80
) (
  input  logic                     clk,
  input  logic                     resetN,
  input  logic                     startOfFrame,
  input  logic [NUM_ENEMIES-1:0]   enemyRequest,
  input  logic [NUM_ENEMIES*11-1:0] enemyTopLeftX,
  input  logic [NUM_ENEMIES*11-1:0] enemyTopLeftY,
  output logic [10:0]              topLeftXout,
  output logic [10:0]              topLeftYout,
  output logic                     headsUpEnable,
  output logic [IDX_W-1:0]         grantIndex
);

  typedef enum logic [1:0] {IDLE, SHOW, GAP} state_t;

  state_t           state, state_nxt;
  logic [IDX_W-1:0] rr_ptr, rr_ptr_nxt, grant_nxt, arb_idx;
  logic [7:0]       frame_cnt, frame_cnt_nxt;
  logic [10:0]      x_nxt, y_nxt;
  logic             arb_hit, do_arb;
  logic [10:0]      pos_x [NUM_ENEMIES];
  logic [10:0]      pos_y [NUM_ENEMIES];

  for (genvar g = 0; g < NUM_ENEMIES; g++) begin : g_unpack
    assign pos_x[g] = enemyTopLeftX[11*g +: 11];
    assign pos_y[g] = enemyTopLeftY[11*g +: 11];
  end

  // Keeps the drawer's "position minus offset" arithmetic from wrapping below zero.
  function automatic logic [10:0] clamp(input logic [10:0] v, input logic [10:0] lo);
    return (v < lo) ? lo : v;
  endfunction

  function automatic logic [IDX_W-1:0] scan_idx(input logic [IDX_W-1:0] ptr, input int k);
    return IDX_W'((int'(ptr) + k) % NUM_ENEMIES);
  endfunction

  // Scan from farthest to nearest so the nearest requester after rr_ptr wins.
  always_comb begin
    arb_hit = 1'b0;
    arb_idx = '0;
    for (int k = NUM_ENEMIES; k >= 1; k--) begin
      if (enemyRequest[scan_idx(rr_ptr, k)]) begin
        arb_hit = 1'b1;
        arb_idx = scan_idx(rr_ptr, k);
      end
    end
  end

  always_comb begin
    state_nxt     = state;
    rr_ptr_nxt    = rr_ptr;
    grant_nxt     = grantIndex;
    frame_cnt_nxt = frame_cnt;
    x_nxt         = topLeftXout;
    y_nxt         = topLeftYout;
    do_arb        = 1'b0;
    if (startOfFrame) begin
      case (state)
        IDLE: do_arb = 1'b1;
        SHOW: begin
          if (!enemyRequest[grantIndex] || frame_cnt == 8'd0) begin
            state_nxt     = GAP;
            frame_cnt_nxt = 8'(GAP_FRAMES - 1);
          end else begin
            frame_cnt_nxt = frame_cnt - 8'd1;
            x_nxt         = clamp(pos_x[grantIndex], 11'(MIN_X));
            y_nxt         = clamp(pos_y[grantIndex], 11'(MIN_Y));
          end
        end
        GAP: begin
          if (frame_cnt == 8'd0) do_arb = 1'b1;
          else frame_cnt_nxt = frame_cnt - 8'd1;
        end
        default: state_nxt = IDLE;
      endcase
      if (do_arb) begin
        if (arb_hit) begin
          state_nxt     = SHOW;
          rr_ptr_nxt    = arb_idx;
          grant_nxt     = arb_idx;
          frame_cnt_nxt = 8'(DISPLAY_FRAMES - 1);
          x_nxt         = clamp(pos_x[arb_idx], 11'(MIN_X));
          y_nxt         = clamp(pos_y[arb_idx], 11'(MIN_Y));
        end else begin
          state_nxt = IDLE;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!resetN) begin
      state         <= IDLE;
      rr_ptr        <= IDX_W'(NUM_ENEMIES - 1);
      grantIndex    <= '0;
      frame_cnt     <= 8'd0;
      topLeftXout   <= 11'(MIN_X);
      topLeftYout   <= 11'(MIN_Y);
      headsUpEnable <= 1'b0;
    end else if (startOfFrame) begin
      state         <= state_nxt;
      rr_ptr        <= rr_ptr_nxt;
      grantIndex    <= grant_nxt;
      frame_cnt     <= frame_cnt_nxt;
      topLeftXout   <= x_nxt;
      topLeftYout   <= y_nxt;
      headsUpEnable <= (state_nxt == SHOW);
    end
  end

endmodule

// File: tb/tb_enemies_headsup_scheduler.sv
// Randomised bench for enemies_headsup_scheduler against a frame-level reference model.
module tb_enemies_headsup_scheduler;
  localparam int N = 4, DISP = 3, GAP = 2, MINX = 5, MINY = 80;

  logic            clk = 1'b0;
  logic            resetN = 1'b0;
  logic            startOfFrame = 1'b0;
  logic [N-1:0]    enemyRequest = '0;
  logic [N*11-1:0] enemyTopLeftX = '0;
  logic [N*11-1:0] enemyTopLeftY = '0;
  logic [10:0]     topLeftXout, topLeftYout;
  logic            headsUpEnable;
  logic [1:0]      grantIndex;

  int total = 0, bad = 0;
  int px[N], py[N];

  // reference model: what is on screen, how long it has been shown, blank frames still owed
  bit m_on;
  int m_idx, m_last, m_shown, m_gap_left, m_x, m_y;

  enemies_headsup_scheduler #(
    .NUM_ENEMIES(N), .IDX_W(2), .DISPLAY_FRAMES(DISP), .GAP_FRAMES(GAP), .MIN_X(MINX), .MIN_Y(MINY)
  ) dut (
    .clk(clk), .resetN(resetN), .startOfFrame(startOfFrame), .enemyRequest(enemyRequest),
    .enemyTopLeftX(enemyTopLeftX), .enemyTopLeftY(enemyTopLeftY),
    .topLeftXout(topLeftXout), .topLeftYout(topLeftYout),
    .headsUpEnable(headsUpEnable), .grantIndex(grantIndex)
  );

  always #5 clk = ~clk;

  function automatic int clampv(input int v, input int lo);
    return (v < lo) ? lo : v;
  endfunction

  function automatic void model_reset();
    m_on = 0; m_idx = 0; m_last = N - 1; m_shown = 0; m_gap_left = 0; m_x = MINX; m_y = MINY;
  endfunction

  function automatic void model_frame(input logic [N-1:0] req);
    bit arb;
    int j;
    arb = 0;
    if (m_on) begin
      if (!req[m_idx] || m_shown >= DISP) begin
        m_on = 0;
        m_gap_left = GAP - 1;
      end else begin
        m_shown++;
        m_x = clampv(px[m_idx], MINX);
        m_y = clampv(py[m_idx], MINY);
      end
    end else if (m_gap_left > 0) begin
      m_gap_left--;
    end else begin
      arb = 1;
    end
    if (arb) begin
      for (int k = 1; k <= N; k++) begin
        j = (m_last + k) % N;
        if (req[j]) begin
          m_on = 1; m_idx = j; m_last = j; m_shown = 1;
          m_x = clampv(px[j], MINX);
          m_y = clampv(py[j], MINY);
          break;
        end
      end
    end
  endfunction

  task automatic drive_pos();
    for (int i = 0; i < N; i++) begin
      enemyTopLeftX[11*i +: 11] = 11'(px[i]);
      enemyTopLeftY[11*i +: 11] = 11'(py[i]);
    end
  endtask

  // One frame start, then garbage on the inputs for the rest of the frame.
  task automatic frame(input logic [N-1:0] req, input int idle);
    @(negedge clk);
    startOfFrame = 1'b1;
    enemyRequest = req;
    drive_pos();
    @(posedge clk);
    #1;
    model_frame(req);
    startOfFrame  = 1'b0;
    enemyRequest  = N'($urandom);
    enemyTopLeftX = {$urandom, $urandom};
    enemyTopLeftY = {$urandom, $urandom};
    repeat (idle) @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    @(negedge clk);
    resetN = 1'b0;
    startOfFrame = 1'b0;
    @(posedge clk);
    #1;
    resetN = 1'b1;
    model_reset();
  endtask

  task automatic test_reset();
    @(negedge clk);
    resetN = 1'b0; startOfFrame = 1'b1; enemyRequest = '1;
    @(posedge clk);
    #1;
    resetN = 1'b1; startOfFrame = 1'b0;
    model_reset();
    total++;
    if (headsUpEnable !== 1'b0 || topLeftXout !== 11'd5 || topLeftYout !== 11'd80 || grantIndex !== 2'd0) begin
      bad++;
      $display("FAIL reset_state: en=%0b x=%0d y=%0d idx=%0d, want en=0 x=5 y=80 idx=0",
               headsUpEnable, topLeftXout, topLeftYout, grantIndex);
    end
    for (int f = 0; f < 5; f++) begin
      frame(4'b0000, 2);
      total++;
      if (headsUpEnable !== 1'b0 || topLeftXout !== 11'd5 || topLeftYout !== 11'd80) begin
        bad++;
        $display("FAIL idle_frame%0d: en=%0b x=%0d y=%0d, want en=0 x=5 y=80",
                 f, headsUpEnable, topLeftXout, topLeftYout);
      end
    end
  endtask

  task automatic test_single();
    logic [7:0] pat;
    pat = 8'b11100111;
    px[2] = 200; py[2] = 150;
    for (int f = 0; f < 8; f++) begin
      frame(4'b0100, 2);
      total++;
      if (headsUpEnable !== pat[7-f] || grantIndex !== 2'd2 || topLeftXout !== 11'd200 || topLeftYout !== 11'd150) begin
        bad++;
        $display("FAIL single_frame%0d: en=%0b idx=%0d x=%0d y=%0d, want en=%0b idx=2 x=200 y=150",
                 f, headsUpEnable, grantIndex, topLeftXout, topLeftYout, pat[7-f]);
      end
    end
  endtask

  task automatic test_round_robin();
    int order[$];
    int exp_order[4];
    bit prev_en;
    exp_order = '{0, 1, 3, 0};
    do_reset();
    prev_en = 0;
    for (int i = 0; i < N; i++) begin px[i] = 100 + 10 * i; py[i] = 200 + 10 * i; end
    for (int f = 0; f < 20; f++) begin
      frame(4'b1011, 1);
      total++;
      if (headsUpEnable !== m_on || (m_on && grantIndex !== 2'(m_idx))) begin
        bad++;
        $display("FAIL rr_frame%0d: en=%0b idx=%0d, want en=%0b idx=%0d", f, headsUpEnable, grantIndex, m_on, m_idx);
      end
      if (headsUpEnable && !prev_en) order.push_back(int'(grantIndex));
      prev_en = headsUpEnable;
    end
    for (int g = 0; g < 4; g++) begin
      total++;
      if (order.size() <= g) begin
        bad++;
        $display("FAIL rr_order%0d: only %0d grants seen, want grant %0d", g, order.size(), exp_order[g]);
      end else if (order[g] != exp_order[g]) begin
        bad++;
        $display("FAIL rr_order%0d: got %0d, want %0d", g, order[g], exp_order[g]);
      end
    end
  endtask

  task automatic test_tracking();
    int exp_x[3];
    logic [2:0] exp_en;
    exp_x = '{100, 104, 104};
    exp_en = 3'b110;
    do_reset();
    py[1] = 300;
    for (int f = 0; f < 3; f++) begin
      px[1] = 100 + 4 * f;
      frame((f == 2) ? 4'b0000 : 4'b0010, 3);
      total++;
      if (headsUpEnable !== exp_en[2-f] || topLeftXout !== 11'(exp_x[f])) begin
        bad++;
        $display("FAIL track_frame%0d: en=%0b x=%0d, want en=%0b x=%0d", f, headsUpEnable, topLeftXout, exp_en[2-f], exp_x[f]);
      end
    end
  endtask

  task automatic test_clamp();
    int ix[3], iy[3], ex[3], ey[3];
    ix = '{2, 300, 5};  iy = '{30, 81, 79};
    ex = '{5, 300, 5};  ey = '{80, 81, 80};
    do_reset();
    for (int f = 0; f < 3; f++) begin
      px[0] = ix[f]; py[0] = iy[f];
      frame(4'b0001, 2);
      total++;
      if (headsUpEnable !== 1'b1 || topLeftXout !== 11'(ex[f]) || topLeftYout !== 11'(ey[f])) begin
        bad++;
        $display("FAIL clamp%0d: en=%0b x=%0d y=%0d, want en=1 x=%0d y=%0d", f, headsUpEnable, topLeftXout, topLeftYout, ex[f], ey[f]);
      end
    end
  endtask

  task automatic test_reset_mid_show();
    do_reset();
    px[0] = 50; py[0] = 90; px[1] = 60; py[1] = 95;
    frame(4'b0010, 2);
    @(negedge clk);
    resetN = 1'b0; startOfFrame = 1'b1; enemyRequest = 4'b0010;
    @(posedge clk);
    #1;
    resetN = 1'b1; startOfFrame = 1'b0;
    model_reset();
    total++;
    if (headsUpEnable !== 1'b0 || topLeftXout !== 11'd5 || topLeftYout !== 11'd80) begin
      bad++;
      $display("FAIL reset_mid_show: en=%0b x=%0d y=%0d, want en=0 x=5 y=80", headsUpEnable, topLeftXout, topLeftYout);
    end
    frame(4'b0011, 2);
    total++;
    if (headsUpEnable !== 1'b1 || grantIndex !== 2'd0 || topLeftXout !== 11'd50) begin
      bad++;
      $display("FAIL regrant_after_reset: en=%0b idx=%0d x=%0d, want en=1 idx=0 x=50", headsUpEnable, grantIndex, topLeftXout);
    end
  endtask

  task automatic test_back_to_back();
    logic [N-1:0] req;
    do_reset();
    req = '0;
    for (int f = 0; f < 300; f++) begin
      if ($urandom_range(0, 3) == 0) req = N'($urandom);
      for (int i = 0; i < N; i++)
        if ($urandom_range(0, 2) == 0) begin px[i] = $urandom_range(0, 2047); py[i] = $urandom_range(0, 2047); end
      frame(req, $urandom_range(0, 3));
      total++;
      if (headsUpEnable !== m_on || grantIndex !== 2'(m_idx) ||
          topLeftXout !== 11'(m_x) || topLeftYout !== 11'(m_y)) begin
        bad++;
        $display("FAIL random_frame%0d: en=%0b idx=%0d x=%0d y=%0d, want en=%0b idx=%0d x=%0d y=%0d",
                 f, headsUpEnable, grantIndex, topLeftXout, topLeftYout, m_on, m_idx, m_x, m_y);
      end
    end
  endtask

  initial begin
    for (int i = 0; i < N; i++) begin px[i] = 0; py[i] = 0; end
    model_reset();
    repeat (2) @(posedge clk);
    test_reset();
    test_single();
    test_round_robin();
    test_tracking();
    test_clamp();
    test_reset_mid_show();
    test_back_to_back();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
